// File: rtl/vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_param
// Parametrised VGA raster timing generator with a built-in test-pattern
// source. A clock divider produces a one-clk pixel enable. Stage 0 holds the
// raster coordinates, which are offered to an external pixel source as
// req_x/req_y. Stage 1 holds the syncs and colour for the pixel that stage 0
// held one pixel period earlier, so every output changes together.
// ---------------------------------------------------------------------------
module vga_timing_gen_param #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIZ    = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_VIZ    = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int CHK_LOG2 = 5,
  parameter int CNT_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               pattern_sel,
  input  logic [R_W+G_W+B_W-1:0]   solid_rgb,
  input  logic [R_W+G_W+B_W-1:0]   ext_rgb,
  output logic                     pix_en,
  output logic [CNT_W-1:0]         req_x,
  output logic [CNT_W-1:0]         req_y,
  output logic                     req_active,
  output logic                     hsync,
  output logic                     vsync,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     frame_start,
  output logic                     line_start
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int PIX_W   = R_W + G_W + B_W;
  localparam int H_TOTAL = H_VIZ + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_VIZ + V_FP + V_PULSE + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIZ_C    = CNT_W'(H_VIZ);
  localparam logic [CNT_W-1:0] V_VIZ_C    = CNT_W'(V_VIZ);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIZ + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIZ + H_FP + H_PULSE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIZ + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIZ + V_FP + V_PULSE);
  // Last pixel index inside one colour bar (bars are H_VIZ/8 pixels wide)
  localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(H_VIZ / 8 - 1);

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_EXT   = 2'd3;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_r;
  logic             pix_en_r;

  // Stage 0: raster position and the bar tracker that follows it
  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic             active_r;
  logic [CNT_W-1:0] bar_px_r;
  logic [2:0]       bar_idx_r;
  logic [1:0]       mode_r;

  // Stage 1: what the monitor actually sees
  logic             hsync_r;
  logic             vsync_r;
  logic [PIX_W-1:0] rgb_r;
  logic             frame_start_r;
  logic             line_start_r;

  // Combinational helpers
  logic [CNT_W-1:0] h_next_s;
  logic [CNT_W-1:0] v_next_s;
  logic             active_next_s;
  logic [CNT_W-1:0] bar_px_next_s;
  logic [2:0]       bar_idx_next_s;
  logic             at_origin_s;
  logic [1:0]       mode_eff_s;
  logic [PIX_W-1:0] pattern_s;
  logic [PIX_W-1:0] rgb_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;

  // -------------------------------------------------------------------------
  // Pixel-rate divider: pix_en is registered so it is low during reset and
  // first rises at clk edge CLK_DIV after reset release.
  // -------------------------------------------------------------------------
  // Divider counter and pixel-enable register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
      pix_en_r  <= 1'b0;
    end else begin
      pix_en_r <= (div_cnt_r == DIV_LAST);
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 0 next-position logic. The bar tracker counts pixels within a bar
  // so no divide by H_VIZ/8 is needed; it restarts whenever the line does.
  // -------------------------------------------------------------------------
  // Next raster position, next active flag and next bar position
  always_comb begin
    h_next_s       = h_cnt_r;
    v_next_s       = v_cnt_r;
    bar_px_next_s  = bar_px_r;
    bar_idx_next_s = bar_idx_r;

    if (h_cnt_r == H_LAST) begin
      h_next_s = '0;
      if (v_cnt_r == V_LAST) begin
        v_next_s = '0;
      end else begin
        v_next_s = v_cnt_r + CNT_ONE;
      end
    end else begin
      h_next_s = h_cnt_r + CNT_ONE;
      v_next_s = v_cnt_r;
    end

    active_next_s = (h_next_s < H_VIZ_C) && (v_next_s < V_VIZ_C);

    if (h_next_s == '0) begin
      bar_px_next_s  = '0;
      bar_idx_next_s = 3'd0;
    end else if (bar_px_r == BAR_LAST) begin
      bar_px_next_s  = '0;
      bar_idx_next_s = bar_idx_r + 3'd1;
    end else begin
      bar_px_next_s  = bar_px_r + CNT_ONE;
      bar_idx_next_s = bar_idx_r;
    end
  end

  // Stage 0 registers advance once per pixel period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r   <= '0;
      v_cnt_r   <= '0;
      active_r  <= 1'b1;
      bar_px_r  <= '0;
      bar_idx_r <= 3'd0;
    end else if (pix_en_r) begin
      h_cnt_r   <= h_next_s;
      v_cnt_r   <= v_next_s;
      active_r  <= active_next_s;
      bar_px_r  <= bar_px_next_s;
      bar_idx_r <= bar_idx_next_s;
    end
  end

  // -------------------------------------------------------------------------
  // Pattern mode is only taken from pattern_sel on the first pixel of a
  // frame. That first pixel already uses the new selection, so the effective
  // mode bypasses the register at the origin.
  // -------------------------------------------------------------------------
  // Effective pattern mode for the pixel currently in stage 0
  always_comb begin
    at_origin_s = (h_cnt_r == '0) && (v_cnt_r == '0);
    if (at_origin_s) begin
      mode_eff_s = pattern_sel;
    end else begin
      mode_eff_s = mode_r;
    end
  end

  // Frame-boundary latch of the pattern selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= PAT_SOLID;
    end else if (pix_en_r && at_origin_s) begin
      mode_r <= pattern_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 next values. Bar colours: index bit 1 clears red (cyan, green,
  // blue, black), bit 2 clears green (magenta, red, blue, black), bit 0
  // clears blue (yellow, green, red, black).
  // -------------------------------------------------------------------------
  // Pattern colour, blanking and sync decode for the stage 0 pixel
  always_comb begin
    case (mode_eff_s)
      PAT_SOLID: pattern_s = solid_rgb;
      PAT_BARS:  pattern_s = {{R_W{~bar_idx_r[1]}},
                              {G_W{~bar_idx_r[2]}},
                              {B_W{~bar_idx_r[0]}}};
      PAT_CHECK: begin
        if (h_cnt_r[CHK_LOG2] ^ v_cnt_r[CHK_LOG2]) begin
          pattern_s = '0;
        end else begin
          pattern_s = '1;
        end
      end
      PAT_EXT:   pattern_s = ext_rgb;
      default:   pattern_s = '0;
    endcase

    if (active_r) begin
      rgb_next_s = pattern_s;
    end else begin
      rgb_next_s = '0;
    end

    if ((h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END)) begin
      hsync_next_s = HS_POL;
    end else begin
      hsync_next_s = ~HS_POL;
    end

    if ((v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END)) begin
      vsync_next_s = VS_POL;
    end else begin
      vsync_next_s = ~VS_POL;
    end
  end

  // Stage 1 output registers, one pixel period behind stage 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_r <= ~HS_POL;
      vsync_r <= ~VS_POL;
      rgb_r   <= '0;
    end else if (pix_en_r) begin
      hsync_r <= hsync_next_s;
      vsync_r <= vsync_next_s;
      rgb_r   <= rgb_next_s;
    end
  end

  // Frame/line markers: single-clk pulses aligned with the stage 1 update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
    end else begin
      frame_start_r <= pix_en_r && at_origin_s;
      line_start_r  <= pix_en_r && (h_cnt_r == '0);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pix_en      = pix_en_r;
  assign req_x       = h_cnt_r;
  assign req_y       = v_cnt_r;
  assign req_active  = active_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign red         = rgb_r[PIX_W-1 -: R_W];
  assign green       = rgb_r[B_W +: G_W];
  assign blue        = rgb_r[0 +: B_W];
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// Testbench for vga_timing_gen_param with a small raster (16x8 visible,
// 24x13 total, 2 clks per pixel, 4-pixel checker squares). The driver
// issues random solid/external colours, steps pattern_sel mid-frame and
// pulses reset mid-frame; for every clk it pushes the expected output
// vector, computed arithmetically from the clk count since reset. A
// monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen_param;

  localparam int CD   = 2;
  localparam int HV   = 16;
  localparam int HF   = 2;
  localparam int HP   = 3;
  localparam int HB   = 3;
  localparam int VV   = 8;
  localparam int VF   = 1;
  localparam int VP   = 2;
  localparam int VB   = 2;
  localparam int CHK  = 2;
  localparam int CW   = 10;
  localparam int HT   = HV + HF + HP + HB;
  localparam int VT   = VV + VF + VP + VB;
  localparam int NCYC = 6300;
  localparam int RST_AT = 3337;

  localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                      8'hE3, 8'hE0, 8'h03, 8'h00};
  localparam int SEL_SEQ [9] = '{0, 3, 1, 2, 3, 0, 2, 1, 3};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    pattern_sel = 2'd0;
  logic [7:0]    solid_rgb = 8'h5A;
  logic [7:0]    ext_rgb = 8'h00;
  logic          pix_en;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
  logic          req_active;
  logic          hsync;
  logic          vsync;
  logic [2:0]    red;
  logic [2:0]    green;
  logic [1:0]    blue;
  logic          frame_start;
  logic          line_start;

  always #5 clk = ~clk;

  vga_timing_gen_param #(
    .CLK_DIV(CD), .H_VIZ(HV), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_VIZ(VV), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .R_W(3), .G_W(3), .B_W(2),
    .CHK_LOG2(CHK), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
    .pix_en(pix_en), .req_x(req_x), .req_y(req_y), .req_active(req_active),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .line_start(line_start)
  );

  typedef struct packed {
    logic          pe;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          act;
    logic          hs;
    logic          vs;
    logic [7:0]    rgb;
    logic          fs;
    logic          ls;
  } vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  int         c;          // clk edges since reset release
  int         mode_m;
  logic       hs_m;
  logic       vs_m;
  logic [7:0] rgb_m;
  logic       fs_m;
  logic       ls_m;
  logic [1:0] cur_sel;
  logic [7:0] cur_solid;
  logic [7:0] cur_ext;

  function automatic logic [7:0] colour(int h, int v, int mode,
                                        logic [7:0] sol, logic [7:0] ext);
    if (h >= HV || v >= VV) return 8'h00;
    case (mode)
      0: return sol;
      1: return BARS[h / (HV / 8)];
      2: return ((((h >> CHK) ^ (v >> CHK)) & 1) == 0) ? 8'hFF : 8'h00;
      default: return ext;
    endcase
  endfunction

  task automatic model_reset();
    c      = 0;
    mode_m = 0;
    hs_m   = 1'b1;
    vs_m   = 1'b1;
    rgb_m  = 8'h00;
    fs_m   = 1'b0;
    ls_m   = 1'b0;
  endtask

  // One clk edge: if the previous clk carried a pixel enable, pixel n is
  // registered using the inputs that were present before this edge.
  task automatic model_edge();
    int n, h, v;
    c = c + 1;
    if (c >= CD + 1 && ((c - 1) % CD) == 0) begin
      n = (c - 1) / CD - 1;
      h = n % HT;
      v = (n / HT) % VT;
      if (h == 0 && v == 0) mode_m = int'(cur_sel);
      rgb_m = colour(h, v, mode_m, cur_solid, cur_ext);
      hs_m  = (h >= HV + HF && h < HV + HF + HP) ? 1'b0 : 1'b1;
      vs_m  = (v >= VV + VF && v < VV + VF + VP) ? 1'b0 : 1'b1;
      fs_m  = (h == 0 && v == 0);
      ls_m  = (h == 0);
    end else begin
      fs_m = 1'b0;
      ls_m = 1'b0;
    end
  endtask

  function automatic vec_t expected();
    vec_t e;
    int a, h, v;
    a = (c >= 1) ? (c - 1) / CD : 0;
    h = a % HT;
    v = (a / HT) % VT;
    e.pe  = (c >= CD) && ((c % CD) == 0);
    e.x   = CW'(h);
    e.y   = CW'(v);
    e.act = (h < HV) && (v < VV);
    e.hs  = hs_m;
    e.vs  = vs_m;
    e.rgb = rgb_m;
    e.fs  = fs_m;
    e.ls  = ls_m;
    return e;
  endfunction

  // Driver: stimulus plus expected-vector generation
  initial begin
    cur_sel   = pattern_sel;
    cur_solid = solid_rgb;
    cur_ext   = ext_rgb;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      rst         = (cyc < 3) || (cyc >= RST_AT && cyc < RST_AT + 3);
      pattern_sel = 2'(SEL_SEQ[cyc / 700]);
      if ((cyc % 50) == 0) solid_rgb = 8'($urandom);
      ext_rgb     = 8'($urandom);
      cur_sel     = pattern_sel;
      cur_solid   = solid_rgb;
      cur_ext     = ext_rgb;
      if (rst) model_reset();
      exp_q.push_back(expected());
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, need 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compare DUT outputs against the queued expectation
  initial begin
    vec_t e;
    vec_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pix_en, req_x, req_y, req_active, hsync, vsync,
             red, green, blue, frame_start, line_start};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec %0d t=%0t: got pe=%b x=%0d y=%0d act=%b hs=%b vs=%b rgb=%h fs=%b ls=%b; exp pe=%b x=%0d y=%0d act=%b hs=%b vs=%b rgb=%h fs=%b ls=%b",
                   vectors, $time, a.pe, a.x, a.y, a.act, a.hs, a.vs, a.rgb,
                   a.fs, a.ls, e.pe, e.x, e.y, e.act, e.hs, e.vs, e.rgb,
                   e.fs, e.ls);
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
Parametrised VGA raster timing generator with a built-in test-pattern source. It derives a pixel-rate enable from clk and runs horizontal and vertical counters over configurable visible, porch and sync intervals. It drives HS/VS with configurable polarity and RGB at configurable widths. Pixel content is solid colour, 8-bar colour bars, checkerboard, or an external pixel source addressed through request coordinates.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=1)
H_VIZ, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_PULSE, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIZ, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_PULSE, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
R_W, 3, red width
G_W, 3, green width
B_W, 2, blue width
CHK_LOG2, 5, checker square size = 2^CHK_LOG2 pixels
CNT_W, 10, coordinate counter width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
pattern_sel  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 external
solid_rgb  in  R_W+G_W+B_W  solid colour {r,g,b}
ext_rgb  in  R_W+G_W+B_W  external pixel for req_x/req_y, same pixel period
pix_en  out  1  one-clk pulse per pixel period
req_x  out  CNT_W  current h counter (stage 0)
req_y  out  CNT_W  current v counter (stage 0)
req_active  out  1  req_x<H_VIZ and req_y<V_VIZ
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
red  out  R_W  pixel red
green  out  G_W  pixel green
blue  out  B_W  pixel blue
frame_start  out  1  one-clk pulse, first output pixel of frame
line_start  out  1  one-clk pulse, first output pixel of each line

Behaviour:
- H_TOTAL=H_VIZ+H_FP+H_PULSE+H_BP; V_TOTAL likewise. Line order: visible, FP, sync, BP.
- Divider counts 0..CLK_DIV-1. pix_en=1 when count==CLK_DIV-1; CLK_DIV=1 gives pix_en constantly 1. After reset the first pix_en occurs at clk edge CLK_DIV after deassertion.
- Stage 0 (h_cnt,v_cnt) advances only on pix_en. h wraps H_TOTAL-1->0 and increments v. v wraps V_TOTAL-1->0 only when h wraps. h/v reset to 0.
- Stage 1 registers update on pix_en from stage-0 values, so latency is exactly 1 pixel period. All outputs are mutually aligned and hold for CLK_DIV clks.
  - hsync=HS_POL when H_VIZ+H_FP <= h < H_VIZ+H_FP+H_PULSE, else ~HS_POL.
  - vsync=VS_POL when V_VIZ+V_FP <= v < V_VIZ+V_FP+V_PULSE, else ~VS_POL.
  - RGB=0 whenever !req_active (blanking is forced regardless of pattern).
- Patterns while active:
  - solid: solid_rgb.
  - bars: 8 bars of H_VIZ/8 px, left to right white, yellow, cyan, green, magenta, red, blue, black. Each component is all-ones or zero. Bar index comes from a bar counter, not a divider.
  - checker: white if h[CHK_LOG2]^v[CHK_LOG2]==0, else black.
  - external: ext_rgb sampled at the pix_en that consumes req_x/req_y.
- pattern_sel is latched into an internal mode register only when stage 0 is at (0,0) on pix_en, so the mode changes only at frame boundaries. Reset mode = solid.
- frame_start (line_start) is registered every clk as pix_en && v==0 && h==0 (pix_en && h==0). It is high for exactly one clk, coincident with the first clk of the output update.
- Reset values: hsync=~HS_POL, vsync=~VS_POL, RGB=0, frame_start=0, line_start=0, pix_en=0, req_x=req_y=0, req_active=1 (counter at 0,0).
- Reset mid-frame: all state returns to reset values immediately. The restart begins a full frame from (0,0) with no partial syncs.

Test Plan:
- Defaults, CLK_DIV=2 -> hsync period 1600 clk, low for 192 clk; vsync period 840000 clk, low for 3200 clk; frame_start every 840000 clk.
- Small params (H 16/2/3/3, V 8/1/2/2, CLK_DIV=1) -> hsync low for h 18..20, vsync low for lines 9..10, RGB=0 outside the 16x8 region, frame_start period 312 clk.
- pattern_sel=1, H_VIZ=16 -> outputs per pair of pixels are FF/FC/1F/1C/E3/E0/03/00 ({r,g,b} RGB332), identical on every active line.
- pattern_sel=2, CHK_LOG2=2 -> (x=0..3,y=0) white, (x=4,y=0) black, (x=4,y=4) white.
- pattern_sel changed 0->3 mid-frame -> output stays solid until the next frame_start. Then RGB equals the ext_rgb driven for req_x/req_y, delayed one pixel.
- rst pulsed at h=100,v=200 -> syncs return to inactive level and RGB=0 within the same clk. The first frame_start comes 1 pixel period after the restart.
